// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter.
// Also hosts the clog2 helper used to size requester IDs.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   localparam int NREQ_DEF      = 4;
   localparam int DSIZE_DEF     = 8;
   localparam int MAX_BURST_DEF = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of valid_i at or after ptr_i.
// Pure combinational, so it can also serve a read-side scheduler.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic            any_valid_o,
   output logic [IDW-1:0]  winner_o
);

   logic [IDW:0] idx;

   assign any_valid_o = |valid_i;

   // Scan farthest offset first so the nearest valid index wins last.
   always_comb begin
      winner_o = '0;
      idx      = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = {1'b0, ptr_i} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(NREQ))
            idx = idx - (IDW+1)'(NREQ);
         if (valid_i[idx[IDW-1:0]])
            winner_o = idx[IDW-1:0];
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A winner keeps the port for up to MAX_BURST beats, tagged with its ID.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ      = NREQ_DEF,
   parameter int DSIZE     = DSIZE_DEF,
   parameter int IDW       = clog2(NREQ),
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*DSIZE-1:0] req_data,
   input  logic [NREQ-1:0]       req_last,
   output logic [NREQ-1:0]       req_ready,
   output logic                  fifo_wen,
   output logic [IDW+DSIZE-1:0]  fifo_wdata,
   input  logic                  fifo_wfull,
   output logic [IDW-1:0]        grant_id,
   output logic                  busy
);

   arb_state_e       state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [3:0]       beat_q, beat_d;
   logic             busy_q, busy_d;

   logic             any_valid;
   logic [IDW-1:0]   winner;
   logic             in_grant;
   logic             g_valid;
   logic             g_last;
   logic [DSIZE-1:0] g_data;
   logic             xfer;
   logic             done;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .valid_i     (req_valid),
      .ptr_i       (rr_ptr_q),
      .any_valid_o (any_valid),
      .winner_o    (winner)
   );

   assign in_grant = (state_q == ARB_GRANT);
   assign g_valid  = req_valid[grant_q];
   assign g_last   = req_last[grant_q];
   assign g_data   = req_data[grant_q*DSIZE +: DSIZE];

   // A full FIFO must never see wen: it advances on any write strobe.
   assign xfer = in_grant && g_valid && !fifo_wfull;
   assign done = (xfer && (g_last || (beat_q + 4'd1 == 4'(MAX_BURST))))
               || (in_grant && !g_valid);

   assign fifo_wen   = xfer;
   assign fifo_wdata = {grant_q, g_data};
   assign grant_id   = grant_q;
   assign busy       = busy_q;

   always_comb begin
      req_ready = '0;
      if (in_grant && !fifo_wfull)
         req_ready[grant_q] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      beat_d   = beat_q;
      busy_d   = busy_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (any_valid) begin
               grant_d = winner;
               beat_d  = '0;
               busy_d  = 1'b1;
               state_d = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (xfer)
               beat_d = beat_q + 4'd1;
            // Explicit wrap keeps this correct for non-power-of-two NREQ.
            if (done) begin
               state_d  = ARB_IDLE;
               busy_d   = 1'b0;
               rr_ptr_d = (grant_q == IDW'(NREQ - 1)) ? '0
                        : grant_q + 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         beat_q   <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         beat_q   <= beat_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues drive beats,
// expected tagged writes are queued up front and matched on fifo_wen.
module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int DSIZE = 8;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*DSIZE-1:0] req_data;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_wen;
   logic [IDW+DSIZE-1:0]  fifo_wdata;
   logic                  fifo_wfull;
   logic [IDW-1:0]        grant_id;
   logic                  busy;

   int n_chk  = 0;
   int n_fail = 0;

   logic [IDW+DSIZE-1:0] exp_q[$];
   logic [DSIZE:0]       bq[NREQ][$];
   logic [NREQ-1:0]      acc = '0;
   int                   cyc = 0;
   int                   wr_cnt = 0;
   int                   wc[4096];
   int                   base;
   int                   g;

   fifo_wr_arbiter #(
      .NREQ      (NREQ),
      .DSIZE     (DSIZE),
      .IDW       (IDW),
      .MAX_BURST (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .fifo_wen   (fifo_wen),
      .fifo_wdata (fifo_wdata),
      .fifo_wfull (fifo_wfull),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic beat(int r, logic [7:0] d, logic l);
      bq[r].push_back({l, d});
   endtask

   task automatic exp_w(int r, logic [7:0] d);
      exp_q.push_back({2'(r), d});
   endtask

   function automatic int pending();
      int s;
      s = exp_q.size();
      for (int i = 0; i < NREQ; i++) s += bq[i].size();
      return s;
   endfunction

   task automatic wait_done(string tag);
      int t;
      t = 0;
      while (pending() != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      chk({tag, "_drain"}, pending(), 0);
      repeat (3) @(posedge clk);
      #2;
   endtask

   // Monitor: observe handshakes and pop the scoreboard on every write.
   initial forever begin
      @(negedge clk);
      cyc++;
      acc = req_ready & req_valid;
      if (fifo_wfull) chk("wen_full", fifo_wen, 0);
      chk("ready_1hot", ($countones(req_ready) <= 1), 1);
      if (fifo_wen) begin
         wc[wr_cnt] = cyc;
         wr_cnt++;
         chk("ready_gid", req_ready, (1 << grant_id));
         if (exp_q.size() == 0) chk("wen_unexp", fifo_wen, 0);
         else chk("wdata", fifo_wdata, exp_q.pop_front());
      end
   end

   // Producers: drop accepted beats after the edge, then present the next.
   initial begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(posedge clk);
         if (rst_n)
            for (int i = 0; i < NREQ; i++)
               if (acc[i] && bq[i].size() > 0) void'(bq[i].pop_front());
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (bq[i].size() > 0) begin
               req_valid[i] = 1'b1;
               {req_last[i], req_data[i*DSIZE +: DSIZE]} = bq[i][0];
            end else begin
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
               req_data[i*DSIZE +: DSIZE] = '0;
            end
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      fifo_wfull = 1'b0;
      #3;
      chk("rst_wen", fifo_wen, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gid", grant_id, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Round-robin, every beat last
      base = wr_cnt;
      for (int n = 0; n < 2; n++)
         for (int i = 0; i < NREQ; i++) begin
            beat(i, 8'(i * 16 + n), 1'b1);
            exp_w(i, 8'(i * 16 + n));
         end
      wait_done("rr");
      chk("rr_span", wc[base+7] - wc[base], 14);

      // Single requester, one arbitration cycle
      base = wr_cnt;
      beat(2, 8'hA1, 1'b0); exp_w(2, 8'hA1);
      beat(2, 8'hA2, 1'b0); exp_w(2, 8'hA2);
      beat(2, 8'hA3, 1'b1); exp_w(2, 8'hA3);
      @(posedge clk); #2;
      @(negedge clk);
      chk("lat_wen", fifo_wen, 0);
      chk("lat_busy", busy, 0);
      @(negedge clk);
      chk("t1_busy", busy, 1);
      chk("t1_gid", grant_id, 2);
      wait_done("single");
      chk("t1_span", wc[base+2] - wc[base], 2);
      chk("t1_busy_end", busy, 0);

      // MAX_BURST forcing hand-off to req 3, then req 1 abandons
      for (int n = 0; n < 10; n++) beat(1, 8'(8'h10 + n), 1'b0);
      @(posedge clk); #2;
      beat(3, 8'h30, 1'b1);
      beat(3, 8'h31, 1'b1);
      for (int n = 0; n < 4; n++) exp_w(1, 8'(8'h10 + n));
      exp_w(3, 8'h30);
      for (int n = 4; n < 8; n++) exp_w(1, 8'(8'h10 + n));
      exp_w(3, 8'h31);
      exp_w(1, 8'h18);
      exp_w(1, 8'h19);
      wait_done("maxb");

      // FIFO full stall mid-burst of req 0
      base = wr_cnt;
      for (int n = 0; n < 6; n++) begin
         beat(0, 8'(8'h40 + n), (n == 5));
         exp_w(0, 8'(8'h40 + n));
      end
      g = 0;
      while (wr_cnt < base + 2 && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      chk("stall_reach", wr_cnt - base, 2);
      fifo_wfull = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stall_ready", req_ready, 0);
         chk("stall_busy", busy, 1);
         chk("stall_gid", grant_id, 0);
      end
      @(posedge clk); #1;
      fifo_wfull = 1'b0;
      wait_done("stall");
      chk("stall_span", wc[base+5] - wc[base], 11);

      // Abandon: req 2 wins over pending req 0, then drops valid
      base = wr_cnt;
      beat(2, 8'h50, 1'b0); exp_w(2, 8'h50);
      beat(0, 8'h51, 1'b1); exp_w(0, 8'h51);
      wait_done("abandon");
      chk("ab_span", wc[base+1] - wc[base], 3);

      // Reset during beat 2 of req 1
      base = wr_cnt;
      for (int n = 0; n < 4; n++) beat(1, 8'(8'h60 + n), (n == 3));
      beat(0, 8'h6F, 1'b1);
      exp_w(1, 8'h60);
      exp_w(1, 8'h61);
      g = 0;
      while (wr_cnt < base + 2 && g < 100) begin
         @(negedge clk); #2;
         g++;
      end
      chk("rst2_reach", wr_cnt - base, 2);
      rst_n = 1'b0;
      #1;
      chk("rst2_wen", fifo_wen, 0);
      chk("rst2_ready", req_ready, 0);
      chk("rst2_busy", busy, 0);
      chk("rst2_gid", grant_id, 0);
      for (int i = 0; i < NREQ; i++) bq[i].delete();
      exp_q.delete();
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
      beat(0, 8'h70, 1'b1); exp_w(0, 8'h70);
      beat(1, 8'h71, 1'b1); exp_w(1, 8'h71);
      wait_done("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one FIFO write port among NREQ producers.
- Each producer presents beats on a valid/ready handshake.
- The winner is locked for a burst of up to MAX_BURST beats.
- Each beat is written to the FIFO tagged with the source ID.
- Sits between the user-project producers (WB/AXI-side engines) and the shared FIFO (wen/wdata/wfull interface).

Parameters:
NREQ, 4, number of requesters (2..8)
DSIZE, 8, payload width per beat
IDW, 2, source-ID tag width; must equal clog2(NREQ)
MAX_BURST, 4, maximum beats per grant before forced re-arbitration (1..15)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
req_valid  input  NREQ  per-requester beat valid
req_data  input  NREQ*DSIZE  per-requester payload; requester i occupies bits [i*DSIZE +: DSIZE]
req_last  input  NREQ  per-requester last-beat-of-burst marker
req_ready  output  NREQ  per-requester accept; one-hot or zero
fifo_wen  output  1  FIFO write enable
fifo_wdata  output  IDW+DSIZE  {grant_id, payload} written to FIFO
fifo_wfull  input  1  FIFO full flag (combinational from FIFO count)
grant_id  output  IDW  currently granted requester
busy  output  1  high while in GRANT state

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0. req_ready=0 and fifo_wen=0 throughout reset.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If any req_valid is high, select the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Register it into grant_id, clear beat_cnt, go to GRANT.
  - Arbitration latency is 1 cycle: no beat transfers in IDLE.
- GRANT:
  - req_ready[grant_id] = !fifo_wfull; all other req_ready bits are 0.
  - fifo_wen = req_valid[grant_id] && !fifo_wfull, purely combinational, same cycle.
  - fifo_wdata = {grant_id, req_data[grant_id]}.
  - Beat transfer = fifo_wen high. On each transfer, beat_cnt increments.
- GRANT exit (to IDLE, with rr_ptr <= (grant_id+1) mod NREQ):
  - (a) transfer with req_last[grant_id]=1;
  - (b) transfer where beat_cnt+1 == MAX_BURST;
  - (c) req_valid[grant_id]=0 in a cycle (requester abandoned).
- FIFO full:
  - fifo_wen must never be asserted while fifo_wfull=1. The FIFO advances its write pointer on any wen, so this is a hard invariant.
  - While full, the grant is held, beat_cnt is frozen, and exit condition (c) is not evaluated if req_valid stays high.
- Fairness: after any grant ends, the granted index has the lowest priority at the next arbitration. The worst-case wait for a continuously valid requester is (NREQ-1) bursts.
- Data stability: req_data and req_last of the granted requester are sampled only in the transfer cycle. Non-granted inputs are ignored.
- Simultaneous: last-beat and MAX_BURST reached in the same transfer cause a single exit. A new request arriving in the exit cycle is arbitrated in the following IDLE cycle.
- Reset mid-burst: asynchronously return to IDLE with rr_ptr=0. The partially written burst remains in the FIFO; FIFO-side flush is the FIFO's own reset.
- Widths: beat_cnt is 4 bits, with no wrap because exit occurs at MAX_BURST. rr_ptr wraps NREQ-1 -> 0 explicitly; no reliance on power-of-two NREQ.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - the state encoding (ARB_IDLE=1'b0, ARB_GRANT=1'b1);
  - the clog2 helper function;
  - the default NREQ/DSIZE/MAX_BURST constants.
- One sub-module, rr_pick: combinational priority pick with rotating start. Inputs: valid vector, rr_ptr. Outputs: any_valid, winner index. It is reusable for a future read-side scheduler.

Test Plan:
- Single requester: req 2 valid with 3 beats (0xA1, 0xA2, 0xA3, last on third), FIFO empty -> 1 idle cycle, then 3 consecutive fifo_wen with wdata 0x2A1, 0x2A2, 0x2A3; busy drops; rr_ptr=3.
- Round-robin: all 4 requesters continuously valid, last on every beat -> grant order 0,1,2,3,0; each write tagged with its ID; one IDLE cycle between grants.
- MAX_BURST: req 1 streams 10 beats, never last, req 3 also valid -> req 1 gets 4 beats, then req 3 is granted before req 1 returns.
- Full stall: fifo_wfull=1 for 5 cycles mid-burst of req 0 -> fifo_wen=0 and req_ready=0 during the stall, grant held, beat_cnt unchanged; burst resumes with no lost or duplicated beat.
- Abandon: req 2 granted, drops valid after 1 beat without last -> exit to IDLE next cycle; rr_ptr=3; pending req 0 granted afterwards.
- Reset mid-burst: assert rst_n=0 during beat 2 of req 1 -> fifo_wen and req_ready go low immediately; after release, state=IDLE, rr_ptr=0, req 0 wins if valid.
